hazard_ctrl: RTL and testbench

- Pipeline control unit that drives the stall, bubble, flush and freeze controls consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards and ID-stage taken branches.
- Freezes the whole pipeline while a multi-cycle data-memory access is outstanding, using a small FSM with a timeout watchdog.
- Sits beside the pipeline registers at the top of the CPU datapath.

---
 rtl/hazard_ctrl_pkg.sv | 20 ++
 rtl/sat_counter.sv | 22 ++
 rtl/hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_hazard_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared opcodes and hazard-controller state encodings for the CPU datapath.
package hazard_ctrl_pkg;

  // Control codes carried in the ID/EX pipeline register.
  localparam logic [3:0] Ctrl_NOP = 4'h0;
  localparam logic [3:0] Ctrl_LW  = 4'h1;
  localparam logic [3:0] Ctrl_SW  = 4'h2;
  localparam logic [3:0] Ctrl_BEQ = 4'h3;

  // Hazard-controller FSM states; 2'b11 is unused and recovers to RUN.
  typedef enum logic [1:0] {
    HC_RUN      = 2'b00,
    HC_MEM_WAIT = 2'b01,
    HC_RELEASE  = 2'b10
  } hc_state_e;

  // Width of the memory-wait watchdog counter (covers TIMEOUT up to 255).
  localparam int WAIT_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear, used for performance counters.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count qualifying cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, ID-stage branch flushes and a
// whole-pipeline freeze while a multi-cycle data-memory access is outstanding.
// Optional build macro PERF_CNT_EN adds saturating cycle/stall/flush counters;
// without it the counter outputs are tied to zero and no counter flops exist.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IFID_RS1addr_i,
  input  logic [4:0]       IFID_RS2addr_i,
  input  logic [3:0]       IDEX_control_i,
  input  logic [4:0]       IDEX_RDaddr_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             hazard_o,
  output logic             branch_o,
  output logic             freeze_o,
  output logic [1:0]       state_o,
  output logic             err_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);

  hc_state_e         state_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_next;
  logic              err_q;
  logic              lu;
  logic              start_wait;
  logic              legal;

  // Load in EX whose destination feeds an operand of the instruction in ID.
  assign lu = (IDEX_control_i == Ctrl_LW) && (IDEX_RDaddr_i != 5'd0) &&
              ((IDEX_RDaddr_i == IFID_RS1addr_i) || (IDEX_RDaddr_i == IFID_RS2addr_i));

  // Saturating increment of the watchdog while the access is still pending.
  assign wait_cnt_next = (wait_cnt_q >= TIMEOUT_V) ? TIMEOUT_V : wait_cnt_q + WAIT_W'(1);

  // Zero-latency pipeline controls from registered state and live inputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    freeze_o   = 1'b0;
    hazard_o   = 1'b0;
    branch_o   = 1'b0;
    pc_write_o = 1'b0;
    start_wait = 1'b0;
    legal      = 1'b1;
    if (rst_i) begin
      unique case (state_q)
        HC_RUN: begin
          if (mem_req_i && !mem_ready_i) begin
            freeze_o   = 1'b1;
            start_wait = 1'b1;
          end else begin
            hazard_o = lu;
            branch_o = branch_taken_i && !lu;
          end
        end
        HC_MEM_WAIT: begin
          if (!mem_ready_i) begin
            freeze_o = 1'b1;
          end else begin
            // Completion cycle is the first unfrozen one: ID advances now, so
            // a branch held across the freeze resolves here.
            hazard_o = lu;
            branch_o = branch_taken_i && !lu;
          end
        end
        HC_RELEASE: begin
          // A re-presented access is ignored here and freezes next cycle.
          hazard_o = lu;
          branch_o = branch_taken_i && !lu;
        end
        default: legal = 1'b0;
      endcase
      pc_write_o = legal && !(freeze_o || hazard_o);
    end
  end

  // FSM, watchdog counter and sticky timeout flag.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= HC_RUN;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      unique case (state_q)
        HC_RUN: begin
          if (start_wait) begin
            state_q    <= HC_MEM_WAIT;
            wait_cnt_q <= WAIT_W'(1);
            if (TIMEOUT_V == WAIT_W'(1)) err_q <= 1'b1;
          end
        end
        HC_MEM_WAIT: begin
          if (mem_ready_i) begin
            state_q <= HC_RELEASE;
          end else begin
            wait_cnt_q <= wait_cnt_next;
            if (wait_cnt_next == TIMEOUT_V) err_q <= 1'b1;
          end
        end
        HC_RELEASE: state_q <= HC_RUN;
        default:    state_q <= HC_RUN;
      endcase
    end
  end

  assign state_o = state_q;
  assign err_o   = err_q;

`ifdef PERF_CNT_EN
  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk(clk_i), .clear(!rst_i), .inc(1'b1), .count(cycle_cnt_o)
  );
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk_i), .clear(!rst_i), .inc(hazard_o || freeze_o), .count(stall_cnt_o)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk_i), .clear(!rst_i), .inc(branch_o), .count(flush_cnt_o)
  );
`else
  assign cycle_cnt_o = '0;
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the pipeline-control rules.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam int SAT     = (1 << CNT_W) - 1;
`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_i;
  logic [4:0]       IFID_RS1addr_i, IFID_RS2addr_i, IDEX_RDaddr_i;
  logic [3:0]       IDEX_control_i;
  logic             branch_taken_i, mem_req_i, mem_ready_i;
  logic             pc_write_o, hazard_o, branch_o, freeze_o, err_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] cycle_cnt_o, stall_cnt_o, flush_cnt_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .IFID_RS1addr_i(IFID_RS1addr_i), .IFID_RS2addr_i(IFID_RS2addr_i),
    .IDEX_control_i(IDEX_control_i), .IDEX_RDaddr_i(IDEX_RDaddr_i),
    .branch_taken_i(branch_taken_i), .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .hazard_o(hazard_o), .branch_o(branch_o),
    .freeze_o(freeze_o), .state_o(state_o), .err_o(err_o),
    .cycle_cnt_o(cycle_cnt_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: tracks whether an access is outstanding, how many
  // consecutive frozen cycles it has cost, and whether it just completed.
  // ---------------------------------------------------------------------------
  bit m_valid = 1'b0;
  bit m_busy, m_rel, m_err;
  int m_wait, m_cyc, m_stall, m_flush;

  always @(negedge clk) begin : model
    bit lu, start, frz, hz, br, pcw, new_rel;
    int st;
    lu = (IDEX_control_i == Ctrl_LW) && (IDEX_RDaddr_i != 0) &&
         (IDEX_RDaddr_i == IFID_RS1addr_i || IDEX_RDaddr_i == IFID_RS2addr_i);
    if (!rst_i) begin
      start = 0; frz = 0; hz = 0; br = 0; pcw = 0;
    end else begin
      start = !m_busy && !m_rel && mem_req_i && !mem_ready_i;
      frz   = start || (m_busy && !mem_ready_i);
      hz    = !frz && lu;
      br    = !frz && !lu && branch_taken_i;
      pcw   = !(frz || hz);
    end
    st = m_busy ? 1 : (m_rel ? 2 : 0);
    if (m_valid) begin
      check("m_freeze",   freeze_o,   frz);
      check("m_hazard",   hazard_o,   hz);
      check("m_branch",   branch_o,   br);
      check("m_pc_write", pc_write_o, pcw);
      check("m_state",    state_o,    st);
      check("m_err",      err_o,      m_err);
      check("m_cycle_cnt", cycle_cnt_o, PERF ? ((m_cyc   > SAT) ? SAT : m_cyc)   : 0);
      check("m_stall_cnt", stall_cnt_o, PERF ? ((m_stall > SAT) ? SAT : m_stall) : 0);
      check("m_flush_cnt", flush_cnt_o, PERF ? ((m_flush > SAT) ? SAT : m_flush) : 0);
    end
    // Advance to the state that the coming posedge produces.
    if (!rst_i) begin
      m_busy = 0; m_rel = 0; m_err = 0; m_wait = 0;
      m_cyc = 0; m_stall = 0; m_flush = 0;
      m_valid = 1'b1;
    end else begin
      m_cyc++;
      if (frz || hz) m_stall++;
      if (br) m_flush++;
      if (frz) begin
        m_wait = start ? 1 : m_wait + 1;
        if (m_wait >= TIMEOUT) m_err = 1;
      end
      new_rel = m_busy && !frz;
      m_busy  = frz;
      m_rel   = new_rel;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus and directed literal checks.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    IFID_RS1addr_i = 5'd0; IFID_RS2addr_i = 5'd0;
    IDEX_control_i = Ctrl_NOP; IDEX_RDaddr_i = 5'd0;
    branch_taken_i = 1'b0; mem_req_i = 1'b0; mem_ready_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b0;
    idle();
    sample();
    check("rst_pc_write", pc_write_o, 0);
    check("rst_freeze",   freeze_o,   0);
    tick();
    tick(); rst_i = 1'b1;
    // c1: idle after reset
    sample();
    check("c1_state", state_o, 2'b00);
    check("c1_err", err_o, 0);
    check("c1_pc_write", pc_write_o, 1);
    check("c1_cycle_cnt", cycle_cnt_o, 0);
    // c2: load-use on rs2
    tick(); IDEX_control_i = Ctrl_LW; IDEX_RDaddr_i = 5'd5; IFID_RS2addr_i = 5'd5;
    sample();
    check("lu_hazard", hazard_o, 1);
    check("lu_pc_write", pc_write_o, 0);
    // c3: load to x0 is never a hazard
    tick(); IDEX_RDaddr_i = 5'd0; IFID_RS2addr_i = 5'd0;
    sample();
    check("lu_x0_hazard", hazard_o, 0);
    check("lu_x0_pc_write", pc_write_o, 1);
    // c4: taken branch without load-use
    tick(); idle(); branch_taken_i = 1'b1;
    sample();
    check("br_branch", branch_o, 1);
    check("br_pc_write", pc_write_o, 1);
    // c5: taken branch suppressed by load-use on rs1
    tick(); IDEX_control_i = Ctrl_LW; IDEX_RDaddr_i = 5'd5; IFID_RS1addr_i = 5'd5;
    sample();
    check("br_lu_branch", branch_o, 0);
    check("br_lu_hazard", hazard_o, 1);
    // c6..c10 idle, counters seen during c11
    tick(); idle();
    repeat (5) tick();
    sample();
    check("perf_cycle", cycle_cnt_o, PERF ? 10 : 0);
    check("perf_stall", stall_cnt_o, PERF ? 2 : 0);
    check("perf_flush", flush_cnt_o, PERF ? 1 : 0);
    repeat (20) tick();
    sample();
    check("perf_cycle_sat", cycle_cnt_o, PERF ? 15 : 0);

    // Memory wait: ready low for three cycles, then high.
    tick(); mem_req_i = 1'b1; mem_ready_i = 1'b0;
    sample(); check("mw_a_freeze", freeze_o, 1); check("mw_a_state", state_o, 2'b00);
    tick(); sample(); check("mw_b_freeze", freeze_o, 1); check("mw_b_state", state_o, 2'b01);
    tick(); sample(); check("mw_c_freeze", freeze_o, 1); check("mw_c_state", state_o, 2'b01);
    tick(); mem_ready_i = 1'b1;
    sample(); check("mw_d_freeze", freeze_o, 0); check("mw_d_state", state_o, 2'b01);
    tick(); mem_ready_i = 1'b0;
    sample(); check("mw_e_freeze", freeze_o, 0); check("mw_e_state", state_o, 2'b10);
    check("mw_e_pc_write", pc_write_o, 1);
    tick(); mem_ready_i = 1'b1;
    sample(); check("mw_f_freeze", freeze_o, 0); check("mw_f_state", state_o, 2'b00);
    tick(); idle();
    sample(); check("mw_g_state", state_o, 2'b00);

    // Timeout with ready held low.
    tick(); mem_req_i = 1'b1;
    sample(); check("to_0_err", err_o, 0);
    tick(); sample(); check("to_1_err", err_o, 0);
    tick(); sample(); check("to_2_err", err_o, 0);
    tick(); sample(); check("to_3_err", err_o, 0);
    tick(); sample(); check("to_4_err", err_o, 1);
    check("to_4_state", state_o, 2'b01); check("to_4_freeze", freeze_o, 1);
    tick(); mem_ready_i = 1'b1;
    sample(); check("to_5_freeze", freeze_o, 0); check("to_5_err", err_o, 1);
    tick(); idle();
    sample(); check("to_6_state", state_o, 2'b10); check("to_6_err", err_o, 1);
    tick(); sample(); check("to_7_err", err_o, 1);

    // Reset asserted mid-wait.
    tick(); mem_req_i = 1'b1;
    sample(); check("rw_0_freeze", freeze_o, 1);
    tick(); sample(); check("rw_1_state", state_o, 2'b01);
    tick(); rst_i = 1'b0;
    sample(); check("rw_2_freeze", freeze_o, 0); check("rw_2_pc_write", pc_write_o, 0);
    tick(); rst_i = 1'b1; idle();
    sample();
    check("rw_3_state", state_o, 2'b00); check("rw_3_err", err_o, 0);
    check("rw_3_cycle_cnt", cycle_cnt_o, 0); check("rw_3_stall_cnt", stall_cnt_o, 0);

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst_i          = ($urandom_range(0, 49) != 0);
      IFID_RS1addr_i = 5'($urandom_range(0, 3));
      IFID_RS2addr_i = 5'($urandom_range(0, 3));
      IDEX_RDaddr_i  = 5'($urandom_range(0, 3));
      IDEX_control_i = 4'($urandom_range(0, 3));
      branch_taken_i = ($urandom_range(0, 3) == 0);
      mem_req_i      = ($urandom_range(0, 3) == 0);
      mem_ready_i    = ($urandom_range(0, 4) < 2);
    end
    tick(); rst_i = 1'b1; idle();
    sample();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
